// File: rtl/truth_table_reader_pkg.sv
// Shared definitions for the truth-table reader: FSM encoding, code-width helper
// and the expected codes of the library gates it characterises.
package truth_table_reader_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_SETTLE = 3'd1;
  localparam state_t ST_SAMPLE = 3'd2;
  localparam state_t ST_NEXT   = 3'd3;
  localparam state_t ST_DONE   = 3'd4;

  // One code bit per input vector.
  function automatic int code_w(input int n_in);
    return 1 << n_in;
  endfunction

  localparam logic [7:0] GATE_0x7E  = 8'h7E;
  localparam logic [7:0] GATE_AND3  = 8'h80;
  localparam logic [7:0] GATE_NAND3 = 8'h7F;
  localparam logic [7:0] GATE_OR3   = 8'hFE;
  localparam logic [7:0] GATE_XOR3  = 8'h96;
  localparam logic [7:0] GATE_MAJ3  = 8'hE8;

endpackage

// File: rtl/truth_table_reader_if.sv
// Request/result handshake between the characterisation harness and the reader.
interface truth_table_reader_if
  import truth_table_reader_pkg::*;
#(
  parameter int N_IN = 3
);
  localparam int CW = code_w(N_IN);

  logic          start;
  logic          busy;
  logic [CW-1:0] result_code;
  logic [CW-1:0] result_unstable;
  logic          result_valid;
  logic          result_ready;

  modport master (
    output start, result_ready,
    input  busy, result_code, result_unstable, result_valid
  );

  modport slave (
    input  start, result_ready,
    output busy, result_code, result_unstable, result_valid
  );

endinterface

// File: rtl/truth_table_reader_row_sampler.sv
// Takes NSAMP consecutive samples of the gate output for one row and reports
// the majority value and whether the samples disagreed, with a one-cycle done.
module tt_row_sampler #(
  parameter int NSAMP = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic sample,
  output logic done,
  output logic majority,
  output logic unstable
);
  localparam int CNT_W = $clog2(NSAMP + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NSAMP - 1);
  localparam logic [CNT_W-1:0] ALL_ONES = CNT_W'(NSAMP);
  localparam logic [CNT_W-1:0] HALF     = CNT_W'(NSAMP / 2);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] ones;
  logic [CNT_W-1:0] ones_next;

  // The verdict includes the sample taken on the final cycle itself.
  assign ones_next = ones + CNT_W'(sample);
  assign done      = en && (cnt == LAST_IDX);
  assign majority  = ones_next > HALF;
  assign unstable  = (ones_next != '0) && (ones_next != ALL_ONES);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      ones <= '0;
    end else if (en && !done) begin
      cnt  <= cnt + CNT_W'(1);
      ones <= ones_next;
    end else begin
      cnt  <= '0;
      ones <= '0;
    end
  end

endmodule

// File: rtl/truth_table_reader.sv
// Sweeps every input vector of a combinational gate, majority-samples its output
// per row and presents the assembled truth-table code with per-row stability flags.
module truth_table_reader
  import truth_table_reader_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int SETTLE = 4,
  parameter int NSAMP  = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  truth_table_reader_if.slave  bus,
  output logic [N_IN-1:0]      stim,
  input  logic                 dut_out
);
  localparam int CW    = code_w(N_IN);
  localparam int SET_W = $clog2(SETTLE + 1);
  localparam logic [N_IN:0]    LAST_ROW   = (N_IN + 1)'(CW - 1);
  localparam logic [SET_W-1:0] SETTLE_END = SET_W'(SETTLE - 1);

  state_t           state;
  logic [N_IN:0]    row;
  logic [SET_W-1:0] settle_cnt;
  logic [CW-1:0]    code_acc;
  logic [CW-1:0]    unst_acc;
  logic             sampling;
  logic             smp_done;
  logic             smp_maj;
  logic             smp_unst;

  assign sampling = (state == ST_SAMPLE);

  tt_row_sampler #(
    .NSAMP (NSAMP)
  ) u_sampler (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (sampling),
    .sample   (dut_out),
    .done     (smp_done),
    .majority (smp_maj),
    .unstable (smp_unst)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= ST_IDLE;
      row                 <= '0;
      settle_cnt          <= '0;
      code_acc            <= '0;
      unst_acc            <= '0;
      stim                <= '0;
      bus.busy            <= 1'b0;
      bus.result_code     <= '0;
      bus.result_unstable <= '0;
      bus.result_valid    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state      <= ST_SETTLE;
            row        <= '0;
            stim       <= '0;
            settle_cnt <= '0;
            code_acc   <= '0;
            unst_acc   <= '0;
            bus.busy   <= 1'b1;
          end
        end

        ST_SETTLE: begin
          if (settle_cnt == SETTLE_END) begin
            settle_cnt <= '0;
            state      <= ST_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + SET_W'(1);
          end
        end

        ST_SAMPLE: begin
          if (smp_done) begin
            code_acc[row[N_IN-1:0]] <= smp_maj;
            unst_acc[row[N_IN-1:0]] <= smp_unst;
            state                   <= ST_NEXT;
          end
        end

        ST_NEXT: begin
          // Results are published only here, so a partial sweep is never visible.
          if (row == LAST_ROW) begin
            bus.result_code     <= code_acc;
            bus.result_unstable <= unst_acc;
            bus.result_valid    <= 1'b1;
            state               <= ST_DONE;
          end else begin
            row   <= row + (N_IN + 1)'(1);
            stim  <= row[N_IN-1:0] + N_IN'(1);
            state <= ST_SETTLE;
          end
        end

        ST_DONE: begin
          if (bus.result_ready) begin
            bus.result_valid <= 1'b0;
            bus.busy         <= 1'b0;
            stim             <= '0;
            row              <= '0;
            state            <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/truth_table_reader.md
Name: truth_table_reader

Overview:
- Characterises a combinational logic gate in the gate library (e.g. the 3-input 0x7E gate) from the outside.
- Sweeps every input combination, waits for the output to settle, samples it several times, and assembles the gate's hex truth-table code.
- Bit k of the code equals the gate output for input vector k, with in1 as the MSB. A correct 0x7E gate therefore reads back as 8'h7E.
- Sits in the characterisation/verification harness alongside library gates and drives them directly.

Parameters:
- N_IN, 3, number of gate inputs (1..4); code width is 2**N_IN.
- SETTLE, 4, cycles to wait after each new input vector before sampling (>=1).
- NSAMP, 3, samples per row; odd, >=1.

Ports:
- clk  input  1  single clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a sweep; accepted only in IDLE.
- stim  output  N_IN  drives the gate inputs {in1,in2,in3}; MSB = in1.
- dut_out  input  1  gate output; synchronous to clk.
- busy  output  1  high from start acceptance until the result is consumed.
- result_code  output  2**N_IN  assembled truth-table code.
- result_unstable  output  2**N_IN  bit k set if the samples of row k disagreed.
- result_valid  output  1  result available; held until consumed.
- result_ready  input  1  consumer accepts the result.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: stim=0, busy=0, result_code=0, result_unstable=0, result_valid=0, FSM=IDLE, all counters=0.
- IDLE:
  - start=1 goes to SETTLE with row=0, stim=0, busy=1.
  - Clears the code and unstable accumulators.
- SETTLE:
  - stim holds the current row.
  - Stays SETTLE cycles, then goes to SAMPLE.
- SAMPLE:
  - Samples dut_out for NSAMP consecutive cycles and counts ones.
  - On the last sample, code[row] = (ones > NSAMP/2), a majority vote.
  - On the last sample, unstable[row] = (ones != 0 && ones != NSAMP).
  - Then goes to NEXT.
- NEXT:
  - If row = 2**N_IN-1, goes to DONE.
  - Otherwise row+1, stim=row+1, and back to SETTLE.
  - NEXT lasts one cycle; stim changes on the NEXT->SETTLE edge.
- DONE:
  - result_valid=1; result_code and result_unstable are stable and held.
  - On result_valid && result_ready: result_valid drops next cycle, busy=0, go to IDLE. stim returns to 0.
- Latency:
  - Each row takes SETTLE+NSAMP+1 cycles.
  - result_valid rises 2**N_IN*(SETTLE+NSAMP+1) cycles after the start-accept edge: 64 with defaults.
- start outside IDLE: ignored, including while in DONE. No queuing.
- Back-pressure: result_ready low in DONE holds everything indefinitely. ready and start asserted together in DONE → the result is consumed and start is ignored.
- Reset mid-sweep: immediate return to reset values. A partial code is never presented.
- Counter widths: row counter N_IN+1 bits, so there is no wrap at row 2**N_IN-1. Settle and sample counters are sized by $clog2(max+1).
- result_code and result_unstable are updated only when DONE is entered. They keep their value through IDLE until the next sweep completes.

Decomposition:
- Shared package holds:
  - state enum: IDLE, SETTLE, SAMPLE, NEXT, DONE;
  - localparam function for code width (2**N_IN);
  - named constants for known gate codes, e.g. GATE_0x7E = 8'h7E.
- One natural sub-module: tt_row_sampler. It takes NSAMP samples and outputs the majority and unstable bits with a done pulse.

Test Plan:
- Behavioural 0x7E gate on stim, start pulse, ready=1 → result_valid at cycle 64; result_code=8'h7E; unstable=8'h00; busy falls the cycle after.
- Constant-0 then constant-1 gates → codes 8'h00 and 8'hFF; stim sequence observed as 0..7, each held 8 cycles.
- Row 5 output toggles every cycle (1,0,1 in SAMPLE) → code bit5=1 by majority; result_unstable=8'h20.
- Gate with 3-cycle output delay and SETTLE=4 → correct 8'h7E. Rerun with SETTLE=1 → mismatch flagged via unstable or wrong code.
- start pulsed in SETTLE, SAMPLE and DONE; ready held 0 for 20 cycles in DONE → single sweep only; valid held steady; consumed on first ready.
- rst_n asserted during row 3 → all outputs 0 asynchronously. A new start afterwards gives a clean 8'h7E.
